// File: rtl/spi_slave_pkg.sv
// Shared constants and mode decode helpers for the SPI byte slave.
package spi_slave_pkg;

  localparam int unsigned SPI_MODE0  = 0;
  localparam int unsigned SPI_MODE1  = 1;
  localparam int unsigned SPI_MODE2  = 2;
  localparam int unsigned SPI_MODE3  = 3;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BIT_CNT_W  = 3;
  localparam int unsigned SYNC_DEPTH = 2;

  function automatic logic mode_cpol(input int unsigned mode);
    return mode[1];
  endfunction

  function automatic logic mode_cpha(input int unsigned mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_sync_2ff.sv
// Single-bit flop synchroniser for an asynchronous pin; reset value is configurable so the
// idle level of the pin can be matched.
module spi_sync_2ff
  import spi_slave_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_D,
  output logic o_Q
);

  logic [SYNC_DEPTH-1:0] r_sync;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync <= {SYNC_DEPTH{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], i_D};
    end
  end

  assign o_Q = r_sync[SYNC_DEPTH-1];

endmodule

// File: rtl/spi_byte_slave.sv
// Oversampled byte-wide SPI slave (MSB first), all logic on i_Clk.
// Define SPI_MISO_TRISTATE_EN to float MISO while not selected.
module spi_byte_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned SPI_MODE = SPI_MODE0
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  output logic              o_RX_DV,
  output logic [BYTE_W-1:0] o_RX_Byte,
  input  logic              i_TX_DV,
  input  logic [BYTE_W-1:0] i_TX_Byte,
  input  logic              i_SPI_Clk,
  output logic              o_SPI_MISO,
  input  logic              i_SPI_MOSI,
  input  logic              i_SPI_CS_n
);

  localparam logic CPOL = mode_cpol(SPI_MODE);
  localparam logic CPHA = mode_cpha(SPI_MODE);

  logic w_sck, w_mosi, w_cs_n;

  spi_sync_2ff #(.RESET_VAL(CPOL)) u_sync_sck (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_D     (i_SPI_Clk),
    .o_Q     (w_sck)
  );

  spi_sync_2ff #(.RESET_VAL(1'b0)) u_sync_mosi (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_D     (i_SPI_MOSI),
    .o_Q     (w_mosi)
  );

  // CS_n resets low so a pin already low at reset release never looks like a falling edge.
  spi_sync_2ff #(.RESET_VAL(1'b0)) u_sync_cs (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_D     (i_SPI_CS_n),
    .o_Q     (w_cs_n)
  );

  logic                 r_sck_q, r_cs_q, r_active, r_skip, r_miso;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [BYTE_W-2:0]    r_rx_shift;
  logic [BYTE_W-1:0]    r_tx_hold, r_tx_shift;

  logic w_sck_rise, w_sck_fall, w_lead, w_trail, w_sel, w_sample, w_shift;
  logic w_cs_fall, w_wrap, w_frame_start, w_miso_bit;
  logic [BYTE_W-1:0] w_tx_next;

  assign w_sck_rise    = w_sck & ~r_sck_q;
  assign w_sck_fall    = ~w_sck & r_sck_q;
  assign w_lead        = CPOL ? w_sck_fall : w_sck_rise;
  assign w_trail       = CPOL ? w_sck_rise : w_sck_fall;
  assign w_sel         = r_active & ~w_cs_n;
  assign w_sample      = w_sel & (CPHA ? w_trail : w_lead);
  assign w_shift       = w_sel & (CPHA ? w_lead : w_trail);
  assign w_cs_fall     = r_cs_q & ~w_cs_n;
  assign w_wrap        = w_sample & (r_bit_cnt == '1);
  assign w_frame_start = w_cs_fall | w_wrap;
  assign w_tx_next     = i_TX_DV ? i_TX_Byte : r_tx_hold;
  assign w_miso_bit    = CPHA ? r_miso : r_tx_shift[BYTE_W-1];

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sck_q  <= CPOL;
      r_cs_q   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_sck_q <= w_sck;
      r_cs_q  <= w_cs_n;
      if (w_cs_n) begin
        r_active <= 1'b0;
      end else if (w_cs_fall) begin
        r_active <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      o_RX_DV    <= 1'b0;
      o_RX_Byte  <= '0;
    end else begin
      o_RX_DV <= w_wrap;
      if (!w_sel) begin
        r_bit_cnt <= '0;
      end else if (w_sample) begin
        r_bit_cnt  <= r_bit_cnt + 1'b1;
        r_rx_shift <= {r_rx_shift[BYTE_W-3:0], w_mosi};
      end
      if (w_wrap) begin
        o_RX_Byte <= {r_rx_shift, w_mosi};
      end
    end
  end

  // With CPHA=0 the wrap reload lands on the 8th leading edge, so the trailing edge that
  // follows must not shift the freshly loaded byte.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_tx_hold  <= '0;
      r_tx_shift <= '0;
      r_skip     <= 1'b0;
      r_miso     <= 1'b1;
    end else begin
      if (i_TX_DV) begin
        r_tx_hold <= i_TX_Byte;
      end
      if (w_frame_start) begin
        r_tx_shift <= w_tx_next;
      end else if (w_shift && !r_skip) begin
        r_tx_shift <= {r_tx_shift[BYTE_W-2:0], 1'b0};
      end
      if (w_wrap) begin
        r_skip <= ~CPHA;
      end else if (w_shift || !w_sel) begin
        r_skip <= 1'b0;
      end
      if (CPHA && w_shift) begin
        r_miso <= r_tx_shift[BYTE_W-1];
      end
    end
  end

`ifdef SPI_MISO_TRISTATE_EN
  assign o_SPI_MISO = w_sel ? w_miso_bit : 1'bz;
`else
  assign o_SPI_MISO = w_sel ? w_miso_bit : 1'b1;
`endif

endmodule

// File: tb/tb_spi_byte_slave.sv
// Bench for spi_byte_slave: one mode-0 and one mode-3 instance behind a shared SPI master.
module tb_spi_byte_slave;

  logic       clk, rst_n;
  logic       sck, mosi, cs_n, sel3;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       cpol, cpha;

  logic       dv0, dv3, miso0, miso3;
  logic [7:0] rx0, rx3;
  logic       cs0, cs3, miso;
  logic [7:0] rx_byte, rd;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         dv_cnt   = 0;
  logic [7:0] rx_q[$];

`ifdef SPI_MISO_TRISTATE_EN
  localparam logic MISO_IDLE = 1'bz;
`else
  localparam logic MISO_IDLE = 1'b1;
`endif

  assign cs0     = cs_n | sel3;
  assign cs3     = cs_n | ~sel3;
  assign miso    = sel3 ? miso3 : miso0;
  assign rx_byte = sel3 ? rx3 : rx0;

  spi_byte_slave #(.SPI_MODE(0)) u_dut0 (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .o_RX_DV    (dv0),
    .o_RX_Byte  (rx0),
    .i_TX_DV    (tx_dv),
    .i_TX_Byte  (tx_byte),
    .i_SPI_Clk  (sck),
    .o_SPI_MISO (miso0),
    .i_SPI_MOSI (mosi),
    .i_SPI_CS_n (cs0)
  );

  spi_byte_slave #(.SPI_MODE(3)) u_dut3 (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .o_RX_DV    (dv3),
    .o_RX_Byte  (rx3),
    .i_TX_DV    (tx_dv),
    .i_TX_Byte  (tx_byte),
    .i_SPI_Clk  (sck),
    .o_SPI_MISO (miso3),
    .i_SPI_MOSI (mosi),
    .i_SPI_CS_n (cs3)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Scoreboard: every DV pulse pops one expected byte.
  always @(negedge clk) begin
    logic [7:0] exp;
    if (rst_n && (dv0 || dv3)) begin
      dv_cnt++;
      exp = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      check("rx_byte_sb", sel3 ? rx3 : rx0, exp);
    end
  end

  task automatic tx_load(input logic [7:0] b);
    @(negedge clk);
    tx_dv   = 1'b1;
    tx_byte = b;
    @(negedge clk);
    tx_dv   = 1'b0;
  endtask

  task automatic cs_assert();
    cs_n = 1'b0;
    #200;
  endtask

  task automatic cs_release();
    #200;
    cs_n = 1'b1;
    #200;
  endtask

  // SCK at 5 MHz; master samples MISO on its sampling edge, MSB first.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi  = tx[i];
        #100;
        rx[i] = miso;
        sck   = ~cpol;
        #100;
        sck   = cpol;
      end else begin
        sck   = ~cpol;
        mosi  = tx[i];
        #100;
        rx[i] = miso;
        sck   = cpol;
        #100;
      end
    end
  endtask

  initial begin
    int dv_before;
    clk = 1'b0; rst_n = 1'b0; sck = 1'b0; mosi = 1'b0; cs_n = 1'b1; sel3 = 1'b0;
    tx_dv = 1'b0; tx_byte = 8'h00; cpol = 1'b0; cpha = 1'b0;
    #35;
    check("reset_dv", {7'b0, dv0}, 8'h00);
    check("reset_rx_byte", rx0, 8'h00);
    check("reset_miso_idle", {7'b0, miso}, {7'b0, MISO_IDLE});
    rst_n = 1'b1;
    #100;

    // Mode 0 single byte
    tx_load(8'h3C);
    rx_q.push_back(8'hA5);
    cs_assert();
    spi_xfer(8'hA5, 8, rd);
    cs_release();
    check("m0_miso_byte", rd, 8'h3C);
    check("m0_dv_count", 8'(dv_cnt), 8'd1);
    check("m0_rx_hold", rx_byte, 8'hA5);
    check("cs_high_miso", {7'b0, miso}, {7'b0, MISO_IDLE});

    // Back-to-back, new TX byte latched mid-frame
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h80);
    cs_assert();
    fork
      spi_xfer(8'h01, 8, rd);
      begin #400; tx_load(8'hC3); end
    join
    check("b2b_miso_first", rd, 8'h3C);
    spi_xfer(8'h80, 8, rd);
    check("b2b_miso_second", rd, 8'hC3);
    cs_release();
    check("b2b_dv_count", 8'(dv_cnt), 8'd3);
    check("b2b_rx_hold", rx_byte, 8'h80);

    // Aborted byte, then full frame; TX byte repeats
    cs_assert();
    spi_xfer(8'hFF, 5, rd);
    cs_release();
    check("abort_no_dv", 8'(dv_cnt), 8'd3);
    rx_q.push_back(8'h5A);
    cs_assert();
    spi_xfer(8'h5A, 8, rd);
    cs_release();
    check("abort_next_miso", rd, 8'hC3);
    check("abort_dv_count", 8'(dv_cnt), 8'd4);

    // Mode 3
    sck = 1'b1; cpol = 1'b1; cpha = 1'b1;
    #200;
    sel3 = 1'b1;
    tx_load(8'h0F);
    rx_q.push_back(8'hF0);
    cs_assert();
    spi_xfer(8'hF0, 8, rd);
    cs_release();
    check("m3_miso_byte", rd, 8'h0F);
    check("m3_dv_count", 8'(dv_cnt), 8'd5);
    check("m3_rx_hold", rx_byte, 8'hF0);

    // SCK toggling while deselected
    dv_before = dv_cnt;
    for (int i = 0; i < 16; i++) begin
      sck = ~sck;
      #100;
    end
    sck = 1'b1;
    #200;
    check("sck_cs_high_no_dv", 8'(dv_cnt - dv_before), 8'd0);

    // Back to mode 0; reset mid-transfer
    sck = 1'b0; cpol = 1'b0; cpha = 1'b0;
    #200;
    sel3 = 1'b0;
    #200;
    cs_assert();
    spi_xfer(8'hFF, 4, rd);
    #50;
    rst_n = 1'b0;
    #1;
    check("rst_mid_dv", {7'b0, dv0}, 8'h00);
    check("rst_mid_rx_byte", rx0, 8'h00);
    check("rst_mid_miso", {7'b0, miso}, 8'h01);
    #100;
    rst_n = 1'b1;
    #200;
    // Remaining bits of the interrupted frame must be ignored
    spi_xfer(8'h0F, 4, rd);
    cs_release();
    check("rst_resume_no_dv", 8'(dv_cnt), 8'd5);
    rx_q.push_back(8'h99);
    cs_assert();
    spi_xfer(8'h99, 8, rd);
    cs_release();
    check("rst_next_miso", rd, 8'h00);
    check("rst_next_dv_count", 8'(dv_cnt), 8'd6);
    check("rst_next_rx_byte", rx_byte, 8'h99);
    check("sb_queue_empty", 8'(rx_q.size()), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_byte_slave.md
Name: spi_byte_slave

Overview:
Byte-oriented SPI slave (MSB first) for host-to-FPGA links; sits under the AXI-Stream SPI bridge. Oversamples the external SPI pins in the system clock domain, so all logic runs on one clock. Each received byte is delivered with a one-cycle valid strobe. A byte loaded by the user is shifted out on MISO during the next byte frame.

Parameters:
SPI_MODE, 0, SPI mode 0..3: CPOL = SPI_MODE[1], CPHA = SPI_MODE[0].

Ports:
i_Clk  in  1  system clock; must run at least 4x the SCK frequency.
i_Rst_L  in  1  asynchronous active-low reset.
o_RX_DV  out  1  one-cycle pulse: o_RX_Byte holds a new byte.
o_RX_Byte  out  8  last complete received byte.
i_TX_DV  in  1  one-cycle strobe: latch i_TX_Byte.
i_TX_Byte  in  8  byte to transmit.
i_SPI_Clk  in  1  SCK from master; asynchronous.
o_SPI_MISO  out  1  serial data to master.
i_SPI_MOSI  in  1  serial data from master; asynchronous.
i_SPI_CS_n  in  1  chip select, active low; asynchronous.

Behaviour:
- Clock and reset: single clock i_Clk; reset i_Rst_L is asynchronous, active-low.
- Reset values: o_RX_DV=0, o_RX_Byte=0x00, TX holding register=0x00, bit counter=0, MISO at idle level.
- Input synchronisation: SCK, MOSI and CS_n each pass through a 2-FF synchroniser. A third SCK stage provides rising/falling edge detection.
- Leading edge = first SCK edge away from CPOL; trailing edge = return to CPOL.
- CPHA=0: sample MOSI on the leading edge, shift MISO on the trailing edge.
- CPHA=1: shift MISO on the leading edge, sample MOSI on the trailing edge.
- RX: shift in MSB first. A 3-bit counter advances on each sample edge while CS_n is low.
- On the 8th sample: update o_RX_Byte and pulse o_RX_DV for exactly one i_Clk cycle. The counter wraps to 0 for back-to-back bytes without a CS release.
- RX latency: o_RX_DV asserts no more than 4 i_Clk cycles after the 8th sampling SCK edge at the pin.
- o_RX_Byte holds its value until the next complete byte.
- TX latch: i_TX_DV copies i_TX_Byte into the holding register at any time. Mid-frame, this does not disturb the active shift register.
- TX frame load: at each frame start, the holding register is copied into the TX shift register. Frame start = synchronised CS_n falling edge, or byte-counter wrap.
- TX repeat: if no new i_TX_DV arrives, the previous byte is re-sent.
- MISO timing, CPHA=0: bit 7 is driven at frame start, before the first SCK edge.
- MISO timing, CPHA=1: bit 7 is driven on the first leading edge.
- MISO when CS_n is high: drives 1.
- CS_n deasserted mid-byte: counter clears and the partial RX byte is discarded (no o_RX_DV). The next CS_n falling edge starts a fresh frame.
- Simultaneous i_TX_DV and frame start in the same cycle: the new i_TX_Byte is the byte loaded into the shift register.
- Reset mid-transfer: all state returns to reset values immediately. The transfer resumes only at the next CS_n falling edge.
- SCK edges while CS_n is high are ignored.

Optional Feature:
SPI_MISO_TRISTATE_EN:
- Defined: o_SPI_MISO is high-impedance whenever synchronised CS_n is high, allowing a shared MISO bus.
- Undefined: MISO drives constant 1 when not selected.

Decomposition:
- Package spi_slave_pkg: mode constants SPI_MODE0..3, BYTE_W=8, BIT_CNT_W=3, and the 2-FF synchroniser depth.
- Sub-module spi_sync_2ff: a single-bit synchroniser with async active-low reset, instantiated 3 times (SCK, MOSI, CS_n).
- Edge detection, RX shifter and TX shifter live in the top module.

Test Plan:
- Mode 0, i_Clk 50 MHz, SCK 5 MHz: load TX 0x3C, master sends 0xA5 under one CS_n → o_RX_Byte=0xA5 with exactly one o_RX_DV pulse; master reads 0x3C.
- Back-to-back 0x01, 0x80 without CS release, TX reloaded with 0xC3 between bytes → two DV pulses carrying 0x01 then 0x80; master reads 0x3C then 0xC3.
- CS_n raised after 5 bits, then a full 0x5A frame → no DV for the aborted byte; a single DV with 0x5A.
- SPI_MODE=3, master sends 0xF0, TX 0x0F → o_RX_Byte=0xF0; master reads 0x0F.
- Assert i_Rst_L=0 after 4 bits → o_RX_DV=0 and o_RX_Byte=0x00; next full frame 0x99 → received correctly.
- CS_n high → MISO=1 (or Z with SPI_MISO_TRISTATE_EN); SCK toggling with CS_n high → no DV.
